// File: rtl/clkdiv_cfg_if.sv
// -----------------------------------------------------------------------------
// clkdiv_cfg_if
// Configuration channel for clkdiv_ctrl.
//
// Handshake: the master holds cfg_valid with cfg_div/cfg_high stable. A
// transfer happens on a clockin posedge where cfg_valid && cfg_ready. The slave
// answers an invalid transfer with a one-cycle cfg_err pulse on the following
// cycle. Without cfg_ready, nothing is consumed and cfg_err stays low.
//
// Signals:
//   cfg_valid  master -> slave  config offer
//   cfg_div    master -> slave  requested divide ratio N
//   cfg_high   master -> slave  requested high time H (clockin cycles)
//   cfg_ready  slave -> master  slave can take a config this cycle
//   cfg_err    slave -> master  one-cycle pulse: last transfer rejected
// -----------------------------------------------------------------------------
interface clkdiv_cfg_if #(
  parameter int CW = 8
);
  logic          cfg_valid;
  logic [CW-1:0] cfg_div;
  logic [CW-1:0] cfg_high;
  logic          cfg_ready;
  logic          cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    output cfg_high,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    input  cfg_high,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/clkdiv_ctrl.sv
// -----------------------------------------------------------------------------
// clkdiv_ctrl
// Programmable, glitch-free clock divider controller. It produces a registered
// divided clock with a run-time divide ratio N and high time H. Start and stop
// happen only on period boundaries. A new configuration is held in a one-deep
// pending register and is applied at the next period boundary, or at once
// when the divider is idle.
//
// Ports:
//   clockin      sole clock (posedge)
//   reset        asynchronous active-low reset
//   enable       level request to run the divider
//   cfg          config channel (clkdiv_cfg_if.slave; handshake in that file)
//   clockout     divided clock, registered: H cycles high, N-H cycles low
//   period_tick  registered pulse during the last cycle of each period
//   active       high while RUN or STOPPING
//   cur_div      divide ratio currently in effect
//   dbg_state_o  FSM state (0 IDLE, 1 RUN, 2 STOPPING)
// -----------------------------------------------------------------------------
module clkdiv_ctrl #(
  parameter int CW       = 8,
  parameter int DEF_DIV  = 6,
  parameter int DEF_HIGH = 3
) (
  input  logic          clockin,
  input  logic          reset,
  input  logic          enable,
  clkdiv_cfg_if.slave   cfg,
  output logic          clockout,
  output logic          period_tick,
  output logic          active,
  output logic [CW-1:0] cur_div,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_e;

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TWO      = CW'(2);
  localparam logic [CW-1:0] DEF_N    = CW'(DEF_DIV);
  localparam logic [CW-1:0] DEF_H    = CW'(DEF_HIGH);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] high_q, high_d;
  logic [CW-1:0] pend_div_q, pend_div_d;
  logic [CW-1:0] pend_high_q, pend_high_d;
  logic          pend_full_q, pend_full_d;
  logic          clk_out_q, clk_out_d;
  logic          tick_q, tick_d;
  logic          cfg_err_q, cfg_err_d;

  logic          last_cyc;
  logic          xfer;
  logic          cfg_ok;
  logic          apply;
  logic          run_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    high_d      = high_q;
    pend_div_d  = pend_div_q;
    pend_high_d = pend_high_q;
    pend_full_d = pend_full_q;
    cfg_err_d   = 1'b0;

    // cnt stays 0 in IDLE and N >= 2, so last_cyc only fires on a real boundary.
    last_cyc = (cnt_q == div_q - ONE);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = last_cyc ? '0 : cnt_q + ONE;
        if (!enable) state_d = S_STOP;
      end
      S_STOP: begin
        // Counting continues so a re-enable resumes without a phase jump.
        cnt_d = last_cyc ? '0 : cnt_q + ONE;
        if (enable)        state_d = S_RUN;
        else if (last_cyc) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Transfer and apply are mutually exclusive: a transfer needs an empty
    // pending register, an apply needs a full one. A config accepted on a
    // boundary edge therefore waits for the following boundary.
    xfer   = cfg.cfg_valid && !pend_full_q;
    cfg_ok = (cfg.cfg_div >= TWO) && (cfg.cfg_high != '0) &&
             (cfg.cfg_high < cfg.cfg_div);
    apply  = pend_full_q && ((state_q == S_IDLE) || last_cyc);

    if (apply) begin
      div_d       = pend_div_q;
      high_d      = pend_high_q;
      pend_full_d = 1'b0;
    end

    if (xfer) begin
      if (cfg_ok) begin
        pend_div_d  = cfg.cfg_div;
        pend_high_d = cfg.cfg_high;
        pend_full_d = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    // Outputs are computed from the next cnt and the config in effect for it,
    // so clockout/period_tick line up with cnt in the cycle they are visible.
    run_d     = (state_d != S_IDLE);
    clk_out_d = run_d && (cnt_d < high_d);
    tick_d    = run_d && (cnt_d == div_d - ONE);
  end

  always_ff @(posedge clockin or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= DEF_N;
      high_q      <= DEF_H;
      pend_div_q  <= '0;
      pend_high_q <= '0;
      pend_full_q <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      high_q      <= high_d;
      pend_div_q  <= pend_div_d;
      pend_high_q <= pend_high_d;
      pend_full_q <= pend_full_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign cfg.cfg_ready = ~pend_full_q;
  assign cfg.cfg_err   = cfg_err_q;
  assign clockout      = clk_out_q;
  assign period_tick   = tick_q;
  assign active        = (state_q != S_IDLE);
  assign cur_div       = div_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_ctrl
// Directed bench for clkdiv_ctrl. A period-position model, which tracks
// whether the divider is producing, its position in the period, and the
// config, supplies expected outputs through exp_q. They are compared every
// cycle. Literal waveform patterns pin the model at key points.
// -----------------------------------------------------------------------------
module tb_clkdiv_ctrl;
  localparam int CW = 8;
  localparam int W  = 5 + CW;

  logic          clockin;
  logic          reset;
  logic          enable;
  logic          clockout;
  logic          period_tick;
  logic          active;
  logic [CW-1:0] cur_div;
  logic [1:0]    dbg_state;

  clkdiv_cfg_if #(.CW(CW)) cfg_if ();

  clkdiv_ctrl #(.CW(CW), .DEF_DIV(6), .DEF_HIGH(3)) dut (
    .clockin     (clockin),
    .reset       (reset),
    .enable      (enable),
    .cfg         (cfg_if),
    .clockout    (clockout),
    .period_tick (period_tick),
    .active      (active),
    .cur_div     (cur_div),
    .dbg_state_o (dbg_state)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clockin = 1'b0;
    forever #5 clockin = ~clockin;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_on, m_stop, m_pos, m_n, m_h, m_pend, m_pn, m_ph;
  logic m_err;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e_v;

  function automatic logic [W-1:0] pack_exp();
    logic ck, tk, ac, rd;
    ck = (m_on != 0) && (m_pos < m_h);
    tk = (m_on != 0) && (m_pos == m_n - 1);
    ac = (m_on != 0);
    rd = (m_pend == 0);
    return {ck, tk, ac, rd, m_err, CW'(m_n)};
  endfunction

  task automatic model_step();
    int d, h;
    bit xfer, ok, wrap, apply;
    d     = int'(cfg_if.cfg_div);
    h     = int'(cfg_if.cfg_high);
    xfer  = cfg_if.cfg_valid && (m_pend == 0);
    ok    = (d >= 2) && (h >= 1) && (h < d);
    wrap  = (m_on != 0) && (m_pos == m_n - 1);
    apply = (m_pend != 0) && ((m_on == 0) || wrap);
    if (m_on == 0) begin
      if (enable) begin
        m_on = 1; m_stop = 0; m_pos = 0;
      end
    end else begin
      m_pos = wrap ? 0 : m_pos + 1;
      if (m_stop != 0) begin
        if (enable) m_stop = 0;
        else if (wrap) m_on = 0;
      end else if (!enable) begin
        m_stop = 1;
      end
    end
    if (apply) begin
      m_n = m_pn; m_h = m_ph; m_pend = 0;
    end
    m_err = 1'b0;
    if (xfer) begin
      if (ok) begin
        m_pn = d; m_ph = h; m_pend = 1;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  always @(posedge clockin or negedge reset) begin
    if (!reset) begin
      m_on = 0; m_stop = 0; m_pos = 0; m_n = 6; m_h = 3;
      m_pend = 0; m_pn = 0; m_ph = 0; m_err = 1'b0;
      exp_q.delete();
      exp_q.push_back(pack_exp());
    end else begin
      model_step();
      exp_q.push_back(pack_exp());
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clockin) begin
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL sb_underrun: no expected entry at %0t", $time);
    end else begin
      e_v = exp_q.pop_front();
      check("sb_clockout",    32'(clockout),      32'(e_v[CW+4]));
      check("sb_period_tick", 32'(period_tick),   32'(e_v[CW+3]));
      check("sb_active",      32'(active),        32'(e_v[CW+2]));
      check("sb_cfg_ready",   32'(cfg_if.cfg_ready), 32'(e_v[CW+1]));
      check("sb_cfg_err",     32'(cfg_if.cfg_err),   32'(e_v[CW]));
      check("sb_cur_div",     32'(cur_div),       32'(e_v[CW-1:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cfg(input bit v, input int d, input int h);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_div   = CW'(d);
    cfg_if.cfg_high  = CW'(h);
  endtask

  task automatic sample(input int n, output logic [31:0] ck, output logic [31:0] tk,
                        output logic [31:0] ac);
    ck = '0; tk = '0; ac = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clockin);
      ck = {ck[30:0], clockout};
      tk = {tk[30:0], period_tick};
      ac = {ac[30:0], active};
    end
  endtask

  task automatic wait_tick(input string name, input int max);
    int k;
    k = 0;
    do begin
      @(negedge clockin);
      k++;
    end while (!period_tick && k < max);
    if (!period_tick) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: no period_tick within %0d cycles", name, max);
    end
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] ck_p, tk_p, ac_p;

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    drive_cfg(1'b0, 0, 0);
    #10 reset = 1'b1;
    check("rst_clockout", 32'(clockout), 0);
    check("rst_active",   32'(active), 0);
    check("rst_cur_div",  32'(cur_div), 6);
    check("rst_ready",    32'(cfg_if.cfg_ready), 1);

    // Default 6/3 waveform.
    @(negedge clockin);
    enable = 1'b1;
    sample(12, ck_p, tk_p, ac_p);
    check("def_clk_pat",  ck_p, 32'b111000111000);
    check("def_tick_pat", tk_p, 32'b000001000001);
    check("def_cur_div",  32'(cur_div), 6);

    // Reconfigure to 4/1 offered at cnt=1.
    @(negedge clockin);
    @(negedge clockin);
    drive_cfg(1'b1, 4, 1);
    @(negedge clockin);
    drive_cfg(1'b0, 0, 0);
    check("pend_ready_low", 32'(cfg_if.cfg_ready), 0);
    sample(12, ck_p, tk_p, ac_p);
    check("r41_clk_pat",  ck_p, 32'b000100010001);
    check("r41_tick_pat", tk_p, 32'b001000100010);
    check("r41_cur_div",  32'(cur_div), 4);

    // Invalid configs.
    @(negedge clockin);
    drive_cfg(1'b1, 1, 0);
    @(negedge clockin);
    check("err_div1", 32'(cfg_if.cfg_err), 1);
    drive_cfg(1'b1, 5, 5);
    @(negedge clockin);
    check("err_h_eq_n", 32'(cfg_if.cfg_err), 1);
    drive_cfg(1'b0, 0, 0);
    @(negedge clockin);
    check("err_cleared", 32'(cfg_if.cfg_err), 0);
    check("err_cur_div", 32'(cur_div), 4);
    check("err_ready",   32'(cfg_if.cfg_ready), 1);

    // Back to 6/3, then disable during the 2nd high cycle.
    drive_cfg(1'b1, 6, 3);
    @(negedge clockin);
    drive_cfg(1'b0, 0, 0);
    wait_tick("to63_tick", 20);
    @(negedge clockin);
    check("to63_cur_div", 32'(cur_div), 6);
    @(negedge clockin);
    enable = 1'b0;
    sample(10, ck_p, tk_p, ac_p);
    check("stop_clk_pat", ck_p, 32'b1000000000);
    check("stop_act_pat", ac_p, 32'b1111000000);

    // Re-enable while STOPPING: sequence continues without a gap.
    enable = 1'b1;
    @(negedge clockin);
    @(negedge clockin);
    enable = 1'b0;
    @(negedge clockin);
    enable = 1'b1;
    sample(12, ck_p, tk_p, ac_p);
    check("reen_clk_pat", ck_p, 32'b000111000111);
    check("reen_act_pat", ac_p, 32'hFFF);

    // 4/1, then asynchronous reset mid-high.
    @(negedge clockin);
    drive_cfg(1'b1, 4, 1);
    @(negedge clockin);
    drive_cfg(1'b0, 0, 0);
    wait_tick("to41_tick", 20);
    @(negedge clockin);
    check("prerst_high",    32'(clockout), 1);
    check("prerst_cur_div", 32'(cur_div), 4);
    #2 reset = 1'b0;
    #1;
    check("async_rst_clockout", 32'(clockout), 0);
    check("async_rst_active",   32'(active), 0);
    check("async_rst_cur_div",  32'(cur_div), 6);
    repeat (2) @(negedge clockin);
    reset = 1'b1;
    sample(12, ck_p, tk_p, ac_p);
    check("post_rst_clk_pat",  ck_p, 32'b111000111000);
    check("post_rst_tick_pat", tk_p, 32'b000001000001);

    // N=2, H=1: toggle every cycle.
    @(negedge clockin);
    drive_cfg(1'b1, 2, 1);
    @(negedge clockin);
    drive_cfg(1'b0, 0, 0);
    wait_tick("to21_tick", 20);
    sample(8, ck_p, tk_p, ac_p);
    check("n2_clk_pat",  ck_p, 32'b10101010);
    check("n2_tick_pat", tk_p, 32'b01010101);

    // Config offered on the boundary edge applies one period later.
    drive_cfg(1'b1, 3, 1);
    @(negedge clockin);
    drive_cfg(1'b0, 0, 0);
    check("bnd_cur_div_old", 32'(cur_div), 2);
    check("bnd_ready_low",   32'(cfg_if.cfg_ready), 0);
    sample(5, ck_p, tk_p, ac_p);
    check("bnd_clk_pat",     ck_p, 32'b01001);
    check("bnd_tick_pat",    tk_p, 32'b10010);
    check("bnd_cur_div_new", 32'(cur_div), 3);

    // Config applied on the next edge while idle.
    enable = 1'b0;
    begin
      int k;
      k = 0;
      while (active && k < 20) begin
        @(negedge clockin);
        k++;
      end
      check("idle_reached", 32'(active), 0);
    end
    drive_cfg(1'b1, 5, 2);
    @(negedge clockin);
    drive_cfg(1'b0, 0, 0);
    check("idle_pend_div",   32'(cur_div), 3);
    check("idle_pend_ready", 32'(cfg_if.cfg_ready), 0);
    @(negedge clockin);
    check("idle_apply_div",   32'(cur_div), 5);
    check("idle_apply_ready", 32'(cfg_if.cfg_ready), 1);
    @(negedge clockin);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
